// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and stall sequencer for the 5-stage RV32I pipeline.
// Drives the PC and ifid/idex/exmem/memwb load and flush controls from the
// imem/dmem handshakes, the load-use detector and the EX branch mispredict.
// A two-state FSM (RUN/SQUASH) tracks a fetch issued to a pre-redirect PC so
// that its stale response is acknowledged and discarded rather than loaded.
// A watchdog raises a sticky mem_timeout after DSTALL_MAX consecutive dmem
// stall cycles.
// Optional macro PIPE_CTRL_PERF_EN adds perf_dstall/perf_flush/perf_bubble.
//
// Handshake: imem_resp is a level held by the icache until if_ack=1 in the
// same cycle; the response is consumed (loaded or discarded) on that edge.
// dmem_req with dmem_resp=0 freezes every stage; dmem_resp=1 completes it.
module pipeline_ctrl #(
    parameter int DSTALL_MAX = 1023,
    parameter int CNT_W      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_resp,
    input  logic        dmem_req,
    input  logic        dmem_resp,
    input  logic        load_use,
    input  logic        br_mispredict,
    output logic        pc_load,
    output logic        if_ack,
    output logic        ifid_load,
    output logic        idex_load,
    output logic        exmem_load,
    output logic        memwb_load,
    output logic        ifid_rst,
    output logic        idex_rst,
    output logic        exmem_rst,
    output logic        memwb_rst,
    output logic        squash_pending,
    output logic        mem_timeout
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_dstall,
    output logic [31:0] perf_flush,
    output logic [31:0] perf_bubble
`endif
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DSTALL_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;
    logic             w_dstall;
    logic             w_flush;
    logic             w_bubble;

    assign w_dstall       = dmem_req & ~dmem_resp;
    assign squash_pending = (r_state == ST_SQUASH);
    assign mem_timeout    = r_timeout;

    // Priority-ordered stage controls and next state; first match wins.
    always_comb begin
        pc_load    = 1'b0;
        if_ack     = 1'b0;
        ifid_load  = 1'b0;
        idex_load  = 1'b0;
        exmem_load = 1'b0;
        memwb_load = 1'b0;
        ifid_rst   = 1'b0;
        idex_rst   = 1'b0;
        exmem_rst  = 1'b0;
        memwb_rst  = 1'b0;
        w_next     = r_state;
        w_flush    = 1'b0;
        w_bubble   = 1'b0;
        if (rst) begin
            ifid_rst  = 1'b1;
            idex_rst  = 1'b1;
            exmem_rst = 1'b1;
            memwb_rst = 1'b1;
        end else if (w_dstall) begin
            // Everything holds; mispredict/load_use are re-presented later.
        end else if (br_mispredict) begin
            w_flush    = 1'b1;
            pc_load    = 1'b1;
            ifid_rst   = 1'b1;
            idex_rst   = 1'b1;
            exmem_load = 1'b1;
            memwb_load = 1'b1;
            if_ack     = imem_resp;
            // A fetch still outstanding belongs to the old path.
            if (!imem_resp) begin
                w_next = ST_SQUASH;
            end
        end else if (r_state == ST_SQUASH) begin
            w_bubble   = 1'b1;
            ifid_rst   = 1'b1;
            idex_load  = 1'b1;
            exmem_load = 1'b1;
            memwb_load = 1'b1;
            if (imem_resp) begin
                if_ack = 1'b1;
                w_next = ST_RUN;
            end
        end else if (load_use) begin
            w_bubble   = 1'b1;
            idex_rst   = 1'b1;
            exmem_load = 1'b1;
            memwb_load = 1'b1;
        end else if (!imem_resp) begin
            w_bubble   = 1'b1;
            ifid_rst   = 1'b1;
            idex_load  = 1'b1;
            exmem_load = 1'b1;
            memwb_load = 1'b1;
        end else begin
            pc_load    = 1'b1;
            if_ack     = 1'b1;
            ifid_load  = 1'b1;
            idex_load  = 1'b1;
            exmem_load = 1'b1;
            memwb_load = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // Dmem stall run counter (saturating) and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else if (w_dstall) begin
            if (r_cnt != CNT_SAT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_cnt == CNT_LAST) begin
                r_timeout <= 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_perf_dstall;
    logic [31:0] r_perf_flush;
    logic [31:0] r_perf_bubble;

    assign perf_dstall = r_perf_dstall;
    assign perf_flush  = r_perf_flush;
    assign perf_bubble = r_perf_bubble;

    // Free-running event counters, wrapping modulo 2**32.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_dstall <= '0;
            r_perf_flush  <= '0;
            r_perf_bubble <= '0;
        end else begin
            if (w_dstall) r_perf_dstall <= r_perf_dstall + 32'd1;
            if (w_flush)  r_perf_flush  <= r_perf_flush + 32'd1;
            if (w_bubble) r_perf_bubble <= r_perf_bubble + 32'd1;
        end
    end
`endif

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Hazard and stall sequencer for the 5-stage RV32I pipeline.
- Drives the load and synchronous-reset (flush) controls of the PC and of the ifid, idex, exmem and memwb pipeline registers.
- Inputs are imem/dmem handshakes, the ID load-use detector and the EX branch-mispredict signal.
- Tracks instruction fetches that are in flight across a redirect, and discards their stale responses.

Parameters:
- DSTALL_MAX, 1023: consecutive dmem-stall cycles before mem_timeout is raised.
- CNT_W, 16: width of the internal dmem-stall run counter; DSTALL_MAX < 2**CNT_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- imem_resp  in  1  fetch response valid; level; held by the icache until if_ack
- dmem_req  in  1  MEM stage holds a load/store
- dmem_resp  in  1  dmem access completes this cycle
- load_use  in  1  ID instr depends on a load currently in EX
- br_mispredict  in  1  EX redirect; PC mux selects the EX target when pc_load=1
- pc_load  out  1  advance/redirect PC
- if_ack  out  1  current imem response consumed (loaded or discarded)
- ifid_load, idex_load, exmem_load, memwb_load  out  1 each  stage register load
- ifid_rst, idex_rst, exmem_rst, memwb_rst  out  1 each  stage register flush (bubble)
- squash_pending  out  1  FSM in SQUASH
- mem_timeout  out  1  sticky watchdog flag

Behaviour:
- Stage controls are combinational from FSM state and inputs. State, counter and mem_timeout are registered.
- During rst:
  - all *_rst=1; all *_load=0; pc_load=0; if_ack=0.
  - state<=RUN; stall counter<=0; mem_timeout<=0.
- FSM states:
  - RUN: normal operation.
  - SQUASH: a fetch to a pre-redirect PC is outstanding.
- Priority, first match wins (when not in rst):
  1. dstall = dmem_req & ~dmem_resp:
     - all loads=0, all rsts=0, pc_load=0, if_ack=0; state unchanged.
     - br_mispredict and load_use are ignored; they are re-presented because the stages hold.
  2. br_mispredict:
     - pc_load=1; ifid_rst=1; idex_rst=1; exmem_load=1; memwb_load=1.
     - If imem_resp=1: if_ack=1 (response discarded).
     - If imem_resp=0: if_ack=0 and next state=SQUASH.
     - If already in SQUASH: stay in SQUASH.
  3. state==SQUASH:
     - pc_load=0; ifid_rst=1; idex/exmem/memwb_load=1.
     - If imem_resp=1: if_ack=1 and next state=RUN.
  4. load_use:
     - pc_load=0; ifid_load=0; idex_rst=1; exmem_load=1; memwb_load=1; if_ack=0.
  5. ~imem_resp:
     - pc_load=0; ifid_rst=1; idex/exmem/memwb_load=1.
  6. otherwise:
     - pc_load=1; if_ack=1; all four loads=1.
- Exclusivity: a given register never has load=1 and rst=1 in the same cycle.
- Watchdog:
  - Counter increments on each dstall cycle and clears on any non-dstall cycle.
  - When counter==DSTALL_MAX-1 and dstall holds, mem_timeout<=1 at the next edge.
  - mem_timeout stays 1 until rst. Counter saturates; no wrap.
  - Pipeline behaviour is unaffected by mem_timeout.
- Reset mid-operation: a rst in SQUASH returns to RUN. The icache is reset in the same cycle, so no stale response survives.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined: adds three 32-bit outputs, all 0 in rst, each wrapping modulo 2**32:
  - perf_dstall: cycles in priority 1.
  - perf_flush: priority-2 events.
  - perf_bubble: cycles in priorities 3, 4 or 5.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset 3 cycles, then imem_resp=1, dmem_req=0 for 5 cycles -> all *_rst=1 during rst; afterwards pc_load=if_ack=1 and all loads=1 every cycle; no rst asserted.
2. Assert load_use for 1 cycle with imem_resp=1 -> pc_load=0, ifid_load=0, idex_rst=1, exmem_load=memwb_load=1, if_ack=0; the next cycle returns to case 6.
3. br_mispredict with imem_resp=0, then imem_resp=1 two cycles later -> cycle 0: pc_load=1, ifid_rst=idex_rst=1, squash_pending=1 from cycle 1; response cycle: if_ack=1, ifid_rst=1, pc_load=0; squash_pending=0 after it.
4. dmem_req=1, dmem_resp=0 for 4 cycles with br_mispredict=1 held -> all controls 0 for 4 cycles; on the dmem_resp=1 cycle the redirect fires once (pc_load=1, ifid_rst=idex_rst=1).
5. DSTALL_MAX=8, dstall held 10 cycles -> mem_timeout rises after the 8th stall cycle and stays 1 after dstall ends, until rst.
6. PIPE_CTRL_PERF_EN defined: 3 dstall cycles, 2 mispredicts (imem_resp=1), 1 load_use -> perf_dstall=3, perf_flush=2, perf_bubble=1.
